// File: rtl/sort_stream_collector.sv
// Result sink for the sorter's serial word stream: rebuilds the packed K*L array
// and flags the first word that breaks ascending sign/exponent/mantissa order.
module sort_stream_collector #(
  parameter int Nk = 23,
  parameter int M  = 8,
  parameter int L  = Nk + M + 1,
  parameter int K  = 10,
  parameter int S  = $clog2(K) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_capture,
  input  logic [L-1:0]   i_din,
  input  logic           i_din_valid,
  output logic [K*L-1:0] o_arr,
  output logic [S-1:0]   o_count,
  output logic           o_done,
  output logic           o_order_err,
  output logic [S-1:0]   o_err_index
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t         r_state;
  logic [K*L-1:0] r_arr;
  logic [S-1:0]   r_count;
  logic           r_done;
  logic           r_order_err;
  logic [S-1:0]   r_err_index;
  logic [L-1:0]   r_prev;

  logic           w_b_sign;
  logic           w_a_sign;
  logic [L-2:0]   w_b_mag;
  logic [L-2:0]   w_a_mag;
  logic           w_less;

  assign w_b_sign = i_din[L-1];
  assign w_a_sign = r_prev[L-1];
  assign w_b_mag  = i_din[L-2:0];
  assign w_a_mag  = r_prev[L-2:0];

  // Sign-magnitude ordering; +0 and -0 must compare equal, so zero is checked first.
  always_comb begin
    w_less = 1'b0;
    if ((w_b_mag == '0) && (w_a_mag == '0))
      w_less = 1'b0;
    else if (w_b_sign != w_a_sign)
      w_less = w_b_sign;
    else if (w_b_sign)
      w_less = (w_b_mag > w_a_mag);
    else
      w_less = (w_b_mag < w_a_mag);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_arr       <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_order_err <= 1'b0;
      r_err_index <= '0;
      r_prev      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_capture) begin
            r_state     <= ST_COLLECT;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_order_err <= 1'b0;
            r_err_index <= '0;
          end
        end
        ST_COLLECT: begin
          if (i_capture) begin
            r_count     <= '0;
            r_done      <= 1'b0;
            r_order_err <= 1'b0;
            r_err_index <= '0;
          end else if (i_din_valid) begin
            for (int i = 0; i < K; i++) begin
              if (r_count == S'(i))
                r_arr[i*L +: L] <= i_din;
            end
            r_prev  <= i_din;
            r_count <= r_count + 1'b1;
            if ((r_count != '0) && w_less && !r_order_err) begin
              r_order_err <= 1'b1;
              r_err_index <= r_count;
            end
            if (r_count == S'(K-1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_arr       = r_arr;
  assign o_count     = r_count;
  assign o_done      = r_done;
  assign o_order_err = r_order_err;
  assign o_err_index = r_err_index;

endmodule

// File: tb/tb_sort_stream_collector.sv
// Bench for sort_stream_collector: directed vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_sort_stream_collector;
  localparam int L = 32;
  localparam int K = 4;
  localparam int S = $clog2(K) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_capture;
  logic [L-1:0]   i_din;
  logic           i_din_valid;
  logic [K*L-1:0] o_arr;
  logic [S-1:0]   o_count;
  logic           o_done;
  logic           o_order_err;
  logic [S-1:0]   o_err_index;

  logic [L-1:0]   k1_arr;
  logic [0:0]     k1_count;
  logic           k1_done;
  logic           k1_order_err;
  logic [0:0]     k1_err_index;

  sort_stream_collector #(.Nk(23), .M(8), .K(K)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_capture(i_capture), .i_din(i_din),
    .i_din_valid(i_din_valid), .o_arr(o_arr), .o_count(o_count), .o_done(o_done),
    .o_order_err(o_order_err), .o_err_index(o_err_index)
  );

  sort_stream_collector #(.Nk(23), .M(8), .K(1)) u_dut_k1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_capture(i_capture), .i_din(i_din),
    .i_din_valid(i_din_valid), .o_arr(k1_arr), .o_count(k1_count), .o_done(k1_done),
    .o_order_err(k1_order_err), .o_err_index(k1_err_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [K*L-1:0] act, input logic [K*L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: list of accepted words plus the retained slot contents.
  bit           m_active;
  bit           m_done;
  logic [L-1:0] m_q[$];
  logic [L-1:0] m_slot[K];

  function automatic longint key(input logic [L-1:0] w);
    longint mag;
    mag = longint'(w[L-2:0]);
    return w[L-1] ? -mag : mag;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_q.delete();
    for (int i = 0; i < K; i++) m_slot[i] = '0;
  endtask

  task automatic model_update(input bit cap, input bit v, input logic [L-1:0] d);
    if (cap) begin
      m_q.delete();
      m_active = 1;
      m_done   = 0;
    end else if (m_active && v) begin
      m_slot[m_q.size()] = d;
      m_q.push_back(d);
      if (m_q.size() == K) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [K*L-1:0] exp_arr;
    bit             exp_err;
    int             exp_idx;
    exp_err = 0;
    exp_idx = 0;
    for (int i = 1; i < m_q.size(); i++) begin
      if (!exp_err && key(m_q[i]) < key(m_q[i-1])) begin
        exp_err = 1;
        exp_idx = i;
      end
    end
    for (int i = 0; i < K; i++) exp_arr[i*L +: L] = m_slot[i];
    chk({tag, ".arr"},   o_arr, exp_arr);
    chk({tag, ".count"}, (K*L)'(o_count), (K*L)'(m_q.size()));
    chk({tag, ".done"},  (K*L)'(o_done), (K*L)'(m_done));
    chk({tag, ".err"},   (K*L)'(o_order_err), (K*L)'(exp_err));
    chk({tag, ".idx"},   (K*L)'(o_err_index), (K*L)'(exp_idx));
  endtask

  task automatic step(input bit cap, input bit v, input logic [L-1:0] d);
    @(negedge clk);
    i_capture   = cap;
    i_din_valid = v;
    i_din       = d;
    @(posedge clk);
    model_update(cap, v, d);
    #1;
  endtask

  typedef struct {
    bit           cap;
    bit           v;
    logic [L-1:0] d;
    int           cnt;
    bit           done;
    bit           err;
    int           idx;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [L-1:0] w;
    logic [K*L-1:0] exp_arr;
    int sel;
    logic [L-1:0] pool[6];

    tbl[0]  = '{1, 0, 32'h0,        0, 0, 0, 0};
    tbl[1]  = '{0, 1, 32'hBF800000, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 32'h00000000, 2, 0, 0, 0};
    tbl[3]  = '{0, 1, 32'h3F800000, 3, 0, 0, 0};
    tbl[4]  = '{0, 1, 32'h40000000, 4, 1, 0, 0};
    tbl[5]  = '{1, 0, 32'h0,        0, 0, 0, 0};
    tbl[6]  = '{0, 1, 32'h40400000, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 32'h3F800000, 2, 0, 1, 1};
    tbl[8]  = '{0, 1, 32'h40000000, 3, 0, 1, 1};
    tbl[9]  = '{0, 1, 32'h3F800000, 4, 1, 1, 1};
    tbl[10] = '{1, 0, 32'h0,        0, 0, 0, 0};
    tbl[11] = '{0, 1, 32'hC0000000, 1, 0, 0, 0};
    tbl[12] = '{0, 1, 32'hBF800000, 2, 0, 0, 0};
    tbl[13] = '{0, 1, 32'h80000000, 3, 0, 0, 0};
    tbl[14] = '{0, 1, 32'h00000000, 4, 1, 0, 0};
    tbl[15] = '{1, 0, 32'h0,        0, 0, 0, 0};
    tbl[16] = '{0, 1, 32'hBF800000, 1, 0, 0, 0};
    tbl[17] = '{0, 1, 32'hC0000000, 2, 0, 1, 1};

    rst_n = 0; i_capture = 0; i_din_valid = 0; i_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.arr", o_arr, '0);
    chk("rst.count", (K*L)'(o_count), '0);
    chk("rst.done", (K*L)'(o_done), '0);
    chk("rst.err", (K*L)'(o_order_err), '0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].cap, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d.count", i), (K*L)'(o_count), (K*L)'(tbl[i].cnt));
      chk($sformatf("tbl%0d.done", i),  (K*L)'(o_done), (K*L)'(tbl[i].done));
      chk($sformatf("tbl%0d.err", i),   (K*L)'(o_order_err), (K*L)'(tbl[i].err));
      chk($sformatf("tbl%0d.idx", i),   (K*L)'(o_err_index), (K*L)'(tbl[i].idx));
      if (i == 4)
        chk("tbl.arr", o_arr, {32'h40000000, 32'h3F800000, 32'h00000000, 32'hBF800000});
    end

    // Gapped stream: words on cycles 0, 3, 4, 9; extra words after done ignored.
    step(1, 0, '0);                 check_model("gap.cap");
    step(0, 1, 32'h3F000000);       check_model("gap.w0");
    chk("k1.done", (K*L)'(k1_done), 1);
    chk("k1.count", (K*L)'(k1_count), 1);
    chk("k1.arr", (K*L)'(k1_arr), (K*L)'(32'h3F000000));
    step(0, 0, 32'h11111111);       check_model("gap.g1");
    step(0, 0, 32'h22222222);       check_model("gap.g2");
    step(0, 1, 32'h3F800000);       check_model("gap.w1");
    step(0, 1, 32'h40000000);       check_model("gap.w2");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'hDEADBEEF);     check_model("gap.g");
    end
    step(0, 1, 32'h40400000);       check_model("gap.w3");
    chk("gap.count", (K*L)'(o_count), 4);
    step(0, 1, 32'h00000001);       check_model("gap.post0");
    step(0, 1, 32'hFFFFFFFF);       check_model("gap.post1");
    chk("gap.arr", o_arr, {32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F000000});
    chk("k1.hold", (K*L)'(k1_arr), (K*L)'(32'h3F000000));
    chk("k1.err", (K*L)'(k1_order_err), 0);

    // Capture with coincident valid from DONE drops the word.
    step(1, 1, 32'h12345678);       check_model("done.cap");
    step(0, 1, 32'h3F800000);       check_model("done.w0");

    // Restart mid-collection after an error; coincident word dropped.
    step(1, 0, '0);                 check_model("rs.cap");
    step(0, 1, 32'h40000000);       check_model("rs.a");
    step(0, 1, 32'h3F800000);       check_model("rs.b");
    chk("rs.err", (K*L)'(o_order_err), 1);
    step(1, 1, 32'h7F000000);       check_model("rs.recap");
    chk("rs.count0", (K*L)'(o_count), 0);
    step(0, 1, 32'hC1000000);       check_model("rs.d");
    step(0, 1, 32'h80000000);       check_model("rs.e");
    step(0, 1, 32'h00000000);       check_model("rs.f");
    step(0, 1, 32'h41000000);       check_model("rs.g");
    chk("rs.arr", o_arr, {32'h41000000, 32'h00000000, 32'h80000000, 32'hC1000000});

    // Async reset between clock edges.
    step(1, 0, '0);
    step(0, 1, 32'h40000000);
    step(0, 1, 32'h3F800000);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("ar.arr", o_arr, '0);
    chk("ar.count", (K*L)'(o_count), '0);
    chk("ar.done", (K*L)'(o_done), '0);
    chk("ar.err", (K*L)'(o_order_err), '0);
    chk("ar.idx", (K*L)'(o_err_index), '0);
    @(negedge clk);
    rst_n = 1;
    step(0, 1, 32'h3F800000);       check_model("ar.nocap");
    chk("ar.count_idle", (K*L)'(o_count), 0);

    // Random traffic against the model.
    pool[0] = 32'h00000000; pool[1] = 32'h80000000; pool[2] = 32'h3F800000;
    pool[3] = 32'hBF800000; pool[4] = 32'h40000000; pool[5] = 32'hC0000000;
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) w = pool[sel];
      else w = $urandom;
      step($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, w);
      check_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sort_stream_collector.md
Name: sort_stream_collector

Overview:
- Receiving end of the sorter's serial result stream: captures K words emitted one per cycle and rebuilds the packed K*L array.
- Checks on the fly that the stream is in ascending order under the sign/exponent/mantissa word format, and flags the first violation.
- Sits downstream of the sorter top level's word output. Used as the result sink in the system and as the self-checking monitor in benches.

Parameters:
- Nk, 23, mantissa width
- M, 8, exponent width
- L, Nk+M+1, word width; bit L-1 = sign, [L-2:Nk] = exponent, [Nk-1:0] = mantissa
- K, 10, number of words per stream
- S, $clog2(K)+1, width of count/index fields

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- capture  input  1  one-cycle pulse arming a new collection
- din  input  L  stream word
- din_valid  input  1  din holds a word this cycle
- arr  output  K*L  collected words; word i at [i*L +: L], first received word at slot 0
- count  output  S  number of words accepted in current collection
- done  output  1  high once K words are accepted; held until next capture or reset
- order_err  output  1  sticky; some word compared smaller than its predecessor
- err_index  output  S  slot index of first out-of-order word; valid only when order_err=1

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; arr=0, count=0, done=0, order_err=0, err_index=0, prev word register=0.
- FSM states IDLE, COLLECT, DONE:
  - IDLE: din_valid ignored. capture=1 -> COLLECT; clear count, done, order_err, err_index. arr is not cleared.
  - COLLECT: each cycle with din_valid=1:
    - arr[count*L +: L] <= din; prev <= din; count <= count+1.
    - Gaps (din_valid=0) are allowed and hold all state.
    - When the K-th word is accepted (count was K-1): -> DONE, done=1 in the next cycle.
  - DONE: din_valid ignored; outputs held. capture=1 -> COLLECT, clearing as in IDLE.
- capture in COLLECT: restarts collection; count=0, flags cleared. A din_valid in the same cycle is dropped (capture wins).
- capture and din_valid in the same cycle from IDLE or DONE: the word is dropped; the first accepted word is the one on the next valid cycle.
- Latency: arr, count and the order flags update 1 cycle after the accepting edge; done rises the cycle after the K-th word.
- Order check:
  - Applied only when count>=1: compare din (b) against prev (a). Violation when b < a:
    - signs differ: the negative word is smaller.
    - both positive: compare {exp, mant} unsigned.
    - both negative: larger {exp, mant} is smaller.
    - +0 (0x00000000) and -0 (0x80000000) are equal; no violation. Equal words are no violation.
  - First violation: order_err <= 1, err_index <= current count (slot of the offending word).
  - Later violations leave err_index unchanged.
- K=1: no comparison ever; done after one word.
- count saturates at K; never wraps. Words after K are ignored by the DONE state.
- No combinational path from inputs to outputs.

Test Plan:
- K=4, capture, then valid words 0xBF800000, 0x00000000, 0x3F800000, 0x40000000 back-to-back -> done=1 one cycle after the 4th word; arr={0x40000000,0x3F800000,0x00000000,0xBF800000} (MSB..LSB); count=4; order_err=0.
- K=4, words 0x40400000, 0x3F800000, 0x40000000, 0x3F800000 -> order_err=1, err_index=1 (first violation only); done=1.
- Sign cases, K=4, words 0xC0000000 (-2), 0xBF800000 (-1), 0x80000000 (-0), 0x00000000 (+0) -> order_err=0. Then capture again with 0xBF800000, 0xC0000000 in the first two slots -> order_err=1, err_index=1.
- Gapped stream: words on cycles 0, 3, 4, 9 with din_valid=0 between -> count steps 1, 2, 3, 4 only on valid edges; arr matches; extra valid words after done are ignored (arr unchanged).
- Restart: capture after 2 words, then 4 new words -> count restarts at 0, old flags cleared, slots 0..3 hold the new words. A din_valid coincident with capture is dropped.
- Async reset: drive reset=0 mid-collection between clock edges -> all outputs 0 immediately. After release, din_valid without capture -> count stays 0.
